// File: rtl/mesi_pkg.sv
// Shared types and defaults for the snoop bus arbiter.
package mesi_pkg;

  localparam int DEF_NUM_CACHES = 4;
  localparam int DEF_ADDR_W     = 20;

  typedef enum logic [1:0] {
    NOP      = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SNOOP = 2'b01,
    DONE  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin picker: the search starts at last+1 and wraps,
// so the previous winner has the lowest priority. Purely combinational.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] w_cand;

  assign any = |req;

  // Scan candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    // NOTE: every variable gets a value before the loop, so no path can
    // leave one unassigned and imply a latch.
    gnt_idx = last;
    w_cand  = last;
    for (int i = 4; i >= 1; i--) begin
      w_cand = last + 2'(i);
      if (req[w_cand]) gnt_idx = w_cand;
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one L1 request at a time round-robin, broadcasts
// it as a snoop, collects one response from every other cache and returns
// the ORed shared/dirty result to the requester.
// Optional feature: define SNP_TIMEOUT_EN to end a snoop after SNP_TIMEOUT
// cycles with resp_err=1; without it a snoop waits indefinitely.
module snoop_bus_arbiter
  import mesi_pkg::*;
#(
  parameter int NUM_CACHES  = DEF_NUM_CACHES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SNP_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CACHES-1:0]        req_valid,
  input  logic [2*NUM_CACHES-1:0]      req_cmd,
  input  logic [NUM_CACHES*ADDR_W-1:0] req_addr,
  output logic [NUM_CACHES-1:0]        req_ready,
  output logic                         snp_valid,
  output logic [1:0]                   snp_cmd,
  output logic [ADDR_W-1:0]            snp_addr,
  output logic [1:0]                   snp_src,
  input  logic [NUM_CACHES-1:0]        snp_resp_valid,
  input  logic [NUM_CACHES-1:0]        snp_shared,
  input  logic [NUM_CACHES-1:0]        snp_dirty,
  output logic                         resp_valid,
  output logic                         resp_shared,
  output logic                         resp_dirty,
  output logic                         resp_err
);

  if (SNP_TIMEOUT < 1) begin : g_bad_timeout
    $error("SNP_TIMEOUT must be at least 1");
  end

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [1:0]              r_last_grant;
  logic [NUM_CACHES-1:0]   r_req_ready;
  logic [NUM_CACHES-1:0]   r_mask;
  logic                    r_shared;
  logic                    r_dirty;
  logic [1:0]              r_snp_src;
  bus_cmd_t                r_snp_cmd;
  logic [ADDR_W-1:0]       r_snp_addr;

  logic [1:0]              w_gnt_idx;
  logic                    w_any;
  logic [NUM_CACHES-1:0]   w_new_resp;
  logic [NUM_CACHES-1:0]   w_mask_next;
  logic                    w_complete;
  logic                    w_timeout;

  rr_arbiter_4 u_rr (
    .req     (req_valid),
    .last    (r_last_grant),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Only first responses from caches not yet done contribute; the source bit
  // is preset in the mask, so its responses are dropped the same way.
  assign w_new_resp  = snp_resp_valid & ~r_mask;
  assign w_mask_next = r_mask | snp_resp_valid;
  assign w_complete  = &w_mask_next;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: one transaction per IDLE -> SNOOP -> DONE round.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = SNOOP;
      SNOOP:   if (w_complete || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Grant, latch the winner's command, and accumulate snoop responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 2'd3;
      r_req_ready  <= '0;
      r_mask       <= '0;
      r_shared     <= 1'b0;
      r_dirty      <= 1'b0;
      r_snp_src    <= '0;
      r_snp_cmd    <= NOP;
      r_snp_addr   <= '0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_req_ready  <= 4'b0001 << w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_snp_src    <= w_gnt_idx;
            r_snp_cmd    <= bus_cmd_t'(req_cmd[{w_gnt_idx, 1'b0} +: 2]);
            r_snp_addr   <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_mask       <= 4'b0001 << w_gnt_idx;
            r_shared     <= 1'b0;
            r_dirty      <= 1'b0;
          end
        end
        SNOOP: begin
          r_mask   <= w_mask_next;
          r_shared <= r_shared | (|(snp_shared & w_new_resp));
          r_dirty  <= r_dirty  | (|(snp_dirty  & w_new_resp));
        end
        default: ;
      endcase
    end
  end

`ifdef SNP_TIMEOUT_EN
  localparam int CNT_W = $clog2(SNP_TIMEOUT + 1);

  logic [CNT_W-1:0] r_snp_cnt;
  logic             r_err;

  assign w_timeout = (r_snp_cnt == CNT_W'(SNP_TIMEOUT - 1));

  // Count SNOOP cycles; flag an error if the last allowed cycle ends incomplete.
  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE) begin
      r_snp_cnt <= '0;
      r_err     <= 1'b0;
    end else if (r_state == SNOOP) begin
      r_snp_cnt <= r_snp_cnt + 1'b1;
      r_err     <= w_timeout && !w_complete;
    end
  end

  assign resp_err = resp_valid & r_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  assign req_ready   = r_req_ready;
  assign snp_valid   = (r_state == SNOOP);
  assign snp_cmd     = r_snp_cmd;
  assign snp_addr    = r_snp_addr;
  assign snp_src     = r_snp_src;
  assign resp_valid  = (r_state == DONE);
  assign resp_shared = resp_valid & r_shared;
  assign resp_dirty  = resp_valid & r_dirty;

endmodule
